// File: rtl/frontier_writer_if.sv
// Node-ID stream and AXI4 write-channel bundles for the frontier write-back stage.
// master drives the forward signals; slave drives ready/response signals.
interface node_stream_if #(
  parameter int NODE_BITS = 32
);
  logic [NODE_BITS-1:0] node_in;
  logic                 node_valid;
  logic                 node_ready;

  modport master (output node_in, output node_valid, input node_ready);
  modport slave  (input node_in, input node_valid, output node_ready);
endinterface

interface axi_wr_if #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64
);
  logic [AXI_ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]                  awlen;
  logic [2:0]                  awsize;
  logic [1:0]                  awburst;
  logic                        awvalid;
  logic                        awready;
  logic [AXI_DATA_WIDTH-1:0]   wdata;
  logic [AXI_DATA_WIDTH/8-1:0] wstrb;
  logic                        wlast;
  logic                        wvalid;
  logic                        wready;
  logic [1:0]                  bresp;
  logic                        bvalid;
  logic                        bready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bresp, bvalid, output bready
  );
  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bresp, bvalid, input bready
  );
endinterface

// File: rtl/frontier_writer.sv
// Packs node IDs two per beat and writes them as aligned AXI4 INCR bursts; AW rises one cycle after fill/flush.
// node_ready is held low from buffer-full until the burst's B response, so only one burst is ever outstanding.
module frontier_writer #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int NODE_BITS      = 32,
  parameter int BURST_BEATS    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [AXI_ADDR_WIDTH-1:0] base_addr,
  input  logic                      flush,
  output logic                      done,
  output logic [31:0]               nodes_written,
  output logic                      wr_error,
  node_stream_if.slave              node,
  axi_wr_if.master                  m_axi
);
  localparam int NODES      = 2 * BURST_BEATS;
  localparam int FILL_W     = $clog2(NODES + 1);
  localparam int BEAT_W     = $clog2(BURST_BEATS + 1);
  localparam int K_W        = $clog2(BURST_BEATS);
  localparam int IDX_W      = $clog2(NODES);
  localparam int ALIGN_BITS = $clog2(BURST_BEATS * 8);
  localparam int STRB_W     = AXI_DATA_WIDTH / 8;
  localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK =
    ~((AXI_ADDR_WIDTH'(1) << ALIGN_BITS) - AXI_ADDR_WIDTH'(1));

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_AW, S_W, S_B, S_DONE} state_t;

  state_t                    state;
  logic [AXI_ADDR_WIDTH-1:0] wr_ptr;
  logic [FILL_W-1:0]         fill;
  logic [BEAT_W-1:0]         beats;
  logic [K_W-1:0]            k;
  logic                      flush_pend;
  logic [NODE_BITS-1:0]      node_buf [NODES];

  logic                      node_ready_r;
  logic                      awvalid_r, wvalid_r, wlast_r, bready_r;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_r;
  logic [7:0]                awlen_r;
  logic [AXI_DATA_WIDTH-1:0] wdata_r;
  logic [STRB_W-1:0]         wstrb_r;

  logic                      accept;
  logic                      flush_now;
  logic [FILL_W-1:0]         fill_inc;
  logic [BEAT_W-1:0]         beats_next;
  logic [K_W-1:0]            k_sel;
  logic [IDX_W-1:0]          lo_idx, hi_idx;
  logic [AXI_DATA_WIDTH-1:0] beat_dat;
  logic [STRB_W-1:0]         beat_strb;

  assign node.node_ready   = node_ready_r;
  assign m_axi.awaddr      = awaddr_r;
  assign m_axi.awlen       = awlen_r;
  assign m_axi.awsize      = 3'b011;
  assign m_axi.awburst     = 2'b01;
  assign m_axi.awvalid     = awvalid_r;
  assign m_axi.wdata       = wdata_r;
  assign m_axi.wstrb       = wstrb_r;
  assign m_axi.wlast       = wlast_r;
  assign m_axi.wvalid      = wvalid_r;
  assign m_axi.bready      = bready_r;

  assign accept     = node.node_valid & node_ready_r;
  assign flush_now  = flush_pend | flush;
  assign fill_inc   = fill + FILL_W'(accept);
  assign beats_next = BEAT_W'((fill_inc + FILL_W'(1)) >> 1);

  // Beat to present next: beat 0 when leaving AW, k+1 while in W.
  // An odd trailing node is padded with all-ones and only its low half is strobed.
  always_comb begin
    k_sel     = (state == S_W) ? k + K_W'(1) : '0;
    lo_idx    = {k_sel, 1'b0};
    hi_idx    = {k_sel, 1'b1};
    beat_dat  = '0;
    beat_strb = '1;
    beat_dat[NODE_BITS-1:0] = node_buf[lo_idx];
    if (FILL_W'(hi_idx) < fill) begin
      beat_dat[AXI_DATA_WIDTH-1:NODE_BITS] = node_buf[hi_idx];
    end else begin
      beat_dat[AXI_DATA_WIDTH-1:NODE_BITS] = '1;
      beat_strb = {{(STRB_W/2){1'b0}}, {(STRB_W/2){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      for (int i = 0; i < NODES; i++) node_buf[i] <= '0;
    end else if (state == S_FILL && accept) begin
      node_buf[fill[IDX_W-1:0]] <= node.node_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      wr_ptr        <= '0;
      fill          <= '0;
      beats         <= '0;
      k             <= '0;
      flush_pend    <= 1'b0;
      node_ready_r  <= 1'b0;
      done          <= 1'b0;
      nodes_written <= '0;
      wr_error      <= 1'b0;
      awvalid_r     <= 1'b0;
      awaddr_r      <= '0;
      awlen_r       <= '0;
      wvalid_r      <= 1'b0;
      wdata_r       <= '0;
      wstrb_r       <= '0;
      wlast_r       <= 1'b0;
      bready_r      <= 1'b0;
    end else begin
      // A flush arriving mid-burst is remembered so it drains after the B response.
      if (flush && state != S_IDLE && state != S_DONE) flush_pend <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start) begin
            wr_ptr        <= base_addr & ALIGN_MASK;
            fill          <= '0;
            nodes_written <= '0;
            wr_error      <= 1'b0;
            flush_pend    <= 1'b0;
            node_ready_r  <= 1'b1;
            state         <= S_FILL;
          end
        end
        S_FILL: begin
          fill <= fill_inc;
          if (fill_inc == FILL_W'(NODES) || (flush_now && fill_inc != '0)) begin
            node_ready_r <= 1'b0;
            awvalid_r    <= 1'b1;
            awaddr_r     <= wr_ptr;
            awlen_r      <= 8'(beats_next - BEAT_W'(1));
            beats        <= beats_next;
            state        <= S_AW;
          end else if (flush_now) begin
            node_ready_r <= 1'b0;
            done         <= 1'b1;
            state        <= S_DONE;
          end
        end
        S_AW: begin
          if (m_axi.awready) begin
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b1;
            wdata_r   <= beat_dat;
            wstrb_r   <= beat_strb;
            wlast_r   <= (BEAT_W'(k_sel) + BEAT_W'(1) == beats);
            k         <= '0;
            state     <= S_W;
          end
        end
        S_W: begin
          if (m_axi.wready) begin
            if (wlast_r) begin
              wvalid_r <= 1'b0;
              wlast_r  <= 1'b0;
              bready_r <= 1'b1;
              state    <= S_B;
            end else begin
              k       <= k_sel;
              wdata_r <= beat_dat;
              wstrb_r <= beat_strb;
              wlast_r <= (BEAT_W'(k_sel) + BEAT_W'(1) == beats);
            end
          end
        end
        S_B: begin
          if (m_axi.bvalid) begin
            bready_r      <= 1'b0;
            nodes_written <= nodes_written + 32'(fill);
            if (m_axi.bresp != 2'b00) wr_error <= 1'b1;
            wr_ptr        <= wr_ptr + AXI_ADDR_WIDTH'({beats, 3'b000});
            fill          <= '0;
            if (flush_now) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              node_ready_r <= 1'b1;
              state        <= S_FILL;
            end
          end
        end
        S_DONE: begin
          done       <= 1'b0;
          flush_pend <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_frontier_writer.sv
// Directed bench for frontier_writer: a logging AXI slave with programmable stalls and
// per-scenario tasks comparing captured bursts against hand-computed values.
module tb_frontier_writer;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic        flush;
  logic        done;
  logic [31:0] nodes_written;
  logic        wr_error;

  node_stream_if #(.NODE_BITS(32)) nif ();
  axi_wr_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64)) axi ();

  frontier_writer #(
    .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .NODE_BITS(32), .BURST_BEATS(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .flush(flush),
    .done(done), .nodes_written(nodes_written), .wr_error(wr_error),
    .node(nif), .m_axi(axi)
  );

  int vectors = 0;
  int miscompares = 0;

  int aw_delay, w_delay, b_delay;
  logic [1:0] bresp_plan [8];

  logic [31:0] aw_addr_q [$];
  logic [7:0]  aw_len_q [$];
  logic [63:0] w_data_q [$];
  logic [7:0]  w_strb_q [$];
  logic        w_last_q [$];
  logic [31:0] nw_at_b_q [$];
  logic        err_at_b_q [$];
  int done_cnt, aw_unstable, w_unstable, nr_violation;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Slave model: everything is sampled and driven on the falling edge.
  initial begin : axi_slave
    int aw_cnt, w_cnt, b_cnt, b_idx;
    logic [31:0] a0;
    logic [7:0]  l0, s0;
    logic [63:0] d0;
    logic        la0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; b_idx = 0;
    a0 = '0; l0 = '0; s0 = '0; d0 = '0; la0 = 1'b0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
    done_cnt = 0; aw_unstable = 0; w_unstable = 0; nr_violation = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; b_idx = 0;
        aw_addr_q.delete(); aw_len_q.delete(); w_data_q.delete(); w_strb_q.delete();
        w_last_q.delete(); nw_at_b_q.delete(); err_at_b_q.delete();
        done_cnt = 0; aw_unstable = 0; w_unstable = 0; nr_violation = 0;
      end else begin
        if (nif.node_ready && (axi.awvalid || axi.wvalid || axi.bready)) nr_violation++;
        if (done) done_cnt++;
        if (axi.awvalid) begin
          if (aw_cnt == 0) begin a0 = axi.awaddr; l0 = axi.awlen; end
          else if (axi.awaddr !== a0 || axi.awlen !== l0) aw_unstable++;
          if (aw_cnt >= aw_delay) begin
            axi.awready = 1'b1;
            aw_addr_q.push_back(axi.awaddr);
            aw_len_q.push_back(axi.awlen);
          end
          aw_cnt++;
        end else begin
          axi.awready = 1'b0; aw_cnt = 0;
        end
        if (axi.wvalid) begin
          if (w_cnt == 0) begin d0 = axi.wdata; s0 = axi.wstrb; la0 = axi.wlast; end
          else if (axi.wdata !== d0 || axi.wstrb !== s0 || axi.wlast !== la0) w_unstable++;
          if (w_cnt >= w_delay) begin
            axi.wready = 1'b1;
            w_data_q.push_back(axi.wdata);
            w_strb_q.push_back(axi.wstrb);
            w_last_q.push_back(axi.wlast);
            w_cnt = 0;
          end else begin
            axi.wready = 1'b0; w_cnt++;
          end
        end else begin
          axi.wready = 1'b0; w_cnt = 0;
        end
        if (axi.bready) begin
          if (!axi.bvalid) begin
            if (b_cnt >= b_delay) begin
              axi.bvalid = 1'b1;
              axi.bresp  = bresp_plan[b_idx & 7];
              nw_at_b_q.push_back(nodes_written);
              err_at_b_q.push_back(wr_error);
              b_idx++;
            end else b_cnt++;
          end
        end else begin
          axi.bvalid = 1'b0; b_cnt = 0;
        end
      end
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; base_addr = '0;
    nif.node_valid = 1'b0; nif.node_in = '0;
    aw_delay = 0; w_delay = 0; b_delay = 0;
    for (int i = 0; i < 8; i++) bresp_plan[i] = 2'b00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_start(input logic [31:0] base);
    @(negedge clk); start = 1'b1; base_addr = base;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_flush();
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
  endtask

  task automatic send_nodes(input int first, input int n);
    int sent, guard;
    logic acc;
    sent = 0; guard = 0;
    while (sent < n && guard < 3000) begin
      @(negedge clk);
      nif.node_valid = 1'b1;
      nif.node_in = 32'(first + sent);
      acc = nif.node_ready;
      @(posedge clk);
      if (acc) sent++;
      guard++;
    end
    @(negedge clk);
    nif.node_valid = 1'b0;
    vectors++; if (sent != n) begin miscompares++; $display("FAIL send_nodes: accepted %0d of %0d", sent, n); end
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++; if (nif.node_ready !== 1'b0) begin miscompares++; $display("FAIL rst_node_ready: got %b want 0", nif.node_ready); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b want 0", done); end
    vectors++; if (nodes_written !== 32'd0) begin miscompares++; $display("FAIL rst_count: got %0d want 0", nodes_written); end
    vectors++; if (wr_error !== 1'b0) begin miscompares++; $display("FAIL rst_wr_error: got %b want 0", wr_error); end
    vectors++; if ({axi.awvalid, axi.wvalid, axi.wlast, axi.bready} !== 4'b0000) begin miscompares++; $display("FAIL rst_axi_ctrl: got %b want 0000", {axi.awvalid, axi.wvalid, axi.wlast, axi.bready}); end
    vectors++; if (axi.awaddr !== 32'd0 || axi.wdata !== 64'd0 || axi.wstrb !== 8'd0) begin miscompares++; $display("FAIL rst_axi_bus: awaddr %h wdata %h wstrb %h want all 0", axi.awaddr, axi.wdata, axi.wstrb); end
    vectors++; if (axi.awsize !== 3'b011 || axi.awburst !== 2'b01) begin miscompares++; $display("FAIL awsize_burst: got %b/%b want 011/01", axi.awsize, axi.awburst); end
  endtask

  task automatic test_full_burst();
    int lasts;
    apply_reset();
    do_start(32'h1000_0000);
    send_nodes(0, 16);
    vectors++; if (axi.awvalid !== 1'b1 || nif.node_ready !== 1'b0) begin miscompares++; $display("FAIL full_aw_latency: awvalid %b node_ready %b want 1/0", axi.awvalid, nif.node_ready); end
    repeat (40) @(negedge clk);
    vectors++; if (aw_addr_q.size() != 1) begin miscompares++; $display("FAIL full_aw_count: got %0d want 1", aw_addr_q.size()); end
    vectors++; if (aw_addr_q[0] !== 32'h1000_0000 || aw_len_q[0] !== 8'd7) begin miscompares++; $display("FAIL full_aw: addr %h len %0d want 10000000/7", aw_addr_q[0], aw_len_q[0]); end
    vectors++; if (w_data_q.size() != 8) begin miscompares++; $display("FAIL full_beats: got %0d want 8", w_data_q.size()); end
    vectors++; if (w_data_q[0] !== 64'h00000001_00000000) begin miscompares++; $display("FAIL full_beat0: got %h want 0000000100000000", w_data_q[0]); end
    vectors++; if (w_data_q[7] !== 64'h0000000F_0000000E || w_strb_q[7] !== 8'hFF) begin miscompares++; $display("FAIL full_beat7: got %h/%h want 0000000f0000000e/ff", w_data_q[7], w_strb_q[7]); end
    lasts = 0;
    foreach (w_last_q[i]) if (w_last_q[i]) lasts++;
    vectors++; if (lasts != 1 || w_last_q[7] !== 1'b1) begin miscompares++; $display("FAIL full_wlast: %0d lasts, beat7 %b want 1/1", lasts, w_last_q[7]); end
    vectors++; if (nodes_written !== 32'd16) begin miscompares++; $display("FAIL full_count: got %0d want 16", nodes_written); end
    vectors++; if (nif.node_ready !== 1'b1) begin miscompares++; $display("FAIL full_refill_ready: got %b want 1", nif.node_ready); end
  endtask

  task automatic test_partial_flush();
    apply_reset();
    do_start(32'h1000_0000);
    send_nodes(0, 35);
    pulse_flush();
    repeat (60) @(negedge clk);
    vectors++; if (aw_addr_q.size() != 3) begin miscompares++; $display("FAIL part_aw_count: got %0d want 3", aw_addr_q.size()); end
    vectors++; if (aw_addr_q[1] !== 32'h1000_0040 || aw_addr_q[2] !== 32'h1000_0080) begin miscompares++; $display("FAIL part_aw_addr: got %h %h want 10000040 10000080", aw_addr_q[1], aw_addr_q[2]); end
    vectors++; if (aw_len_q[0] !== 8'd7 || aw_len_q[1] !== 8'd7 || aw_len_q[2] !== 8'd1) begin miscompares++; $display("FAIL part_aw_len: got %0d %0d %0d want 7 7 1", aw_len_q[0], aw_len_q[1], aw_len_q[2]); end
    vectors++; if (w_data_q.size() != 18) begin miscompares++; $display("FAIL part_beats: got %0d want 18", w_data_q.size()); end
    vectors++; if (w_data_q[16] !== 64'h00000021_00000020 || w_strb_q[16] !== 8'hFF || w_last_q[16] !== 1'b0) begin miscompares++; $display("FAIL part_beat16: got %h/%h/%b want 0000002100000020/ff/0", w_data_q[16], w_strb_q[16], w_last_q[16]); end
    vectors++; if (w_data_q[17] !== 64'hFFFFFFFF_00000022 || w_strb_q[17] !== 8'h0F || w_last_q[17] !== 1'b1) begin miscompares++; $display("FAIL part_beat17: got %h/%h/%b want ffffffff00000022/0f/1", w_data_q[17], w_strb_q[17], w_last_q[17]); end
    vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL part_done: %0d cycles high want 1", done_cnt); end
    vectors++; if (nodes_written !== 32'd35 || wr_error !== 1'b0) begin miscompares++; $display("FAIL part_count: got %0d err %b want 35/0", nodes_written, wr_error); end
  endtask

  task automatic test_flush_empty();
    int d0;
    apply_reset();
    do_start(32'h1000_0000);
    pulse_flush();
    repeat (10) @(negedge clk);
    vectors++; if (aw_addr_q.size() != 0) begin miscompares++; $display("FAIL empty_aw: got %0d bursts want 0", aw_addr_q.size()); end
    vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL empty_done: %0d cycles high want 1", done_cnt); end
    vectors++; if (nodes_written !== 32'd0) begin miscompares++; $display("FAIL empty_count: got %0d want 0", nodes_written); end
    d0 = done_cnt;
    pulse_flush();
    repeat (10) @(negedge clk);
    vectors++; if (done_cnt != d0 || nif.node_ready !== 1'b0) begin miscompares++; $display("FAIL idle_flush: done pulses %0d node_ready %b want 0/0", done_cnt - d0, nif.node_ready); end
  endtask

  task automatic test_stall();
    apply_reset();
    aw_delay = 5; w_delay = 5; b_delay = 3;
    do_start(32'h2000_0000);
    send_nodes(0, 16);
    // start outside IDLE must not move the write pointer
    @(negedge clk); start = 1'b1; base_addr = 32'h3000_0000;
    @(negedge clk); start = 1'b0;
    vectors++; if (nodes_written !== 32'd0) begin miscompares++; $display("FAIL stall_early_count: got %0d want 0", nodes_written); end
    repeat (120) @(negedge clk);
    vectors++; if (nodes_written !== 32'd16) begin miscompares++; $display("FAIL stall_count: got %0d want 16", nodes_written); end
    vectors++; if (nw_at_b_q.size() != 1 || nw_at_b_q[0] !== 32'd0) begin miscompares++; $display("FAIL stall_count_before_b: got %0d want 0", nw_at_b_q[0]); end
    send_nodes(16, 2);
    pulse_flush();
    repeat (150) @(negedge clk);
    vectors++; if (aw_unstable != 0 || w_unstable != 0) begin miscompares++; $display("FAIL stall_stable: aw %0d w %0d changes want 0/0", aw_unstable, w_unstable); end
    vectors++; if (nr_violation != 0) begin miscompares++; $display("FAIL stall_node_ready: %0d busy cycles ready want 0", nr_violation); end
    vectors++; if (aw_addr_q.size() != 2 || aw_addr_q[1] !== 32'h2000_0040 || aw_len_q[1] !== 8'd0) begin miscompares++; $display("FAIL stall_aw2: n %0d addr %h len %0d want 2/20000040/0", aw_addr_q.size(), aw_addr_q[1], aw_len_q[1]); end
    vectors++; if (w_data_q.size() != 9 || w_data_q[8] !== 64'h00000011_00000010 || w_strb_q[8] !== 8'hFF || w_last_q[8] !== 1'b1) begin miscompares++; $display("FAIL stall_beat8: n %0d data %h strb %h last %b", w_data_q.size(), w_data_q[8], w_strb_q[8], w_last_q[8]); end
    vectors++; if (nodes_written !== 32'd18 || done_cnt != 1) begin miscompares++; $display("FAIL stall_final: count %0d done %0d want 18/1", nodes_written, done_cnt); end
  endtask

  task automatic test_bresp_error();
    apply_reset();
    bresp_plan[0] = 2'b10;
    do_start(32'h1000_0000);
    send_nodes(0, 32);
    repeat (40) @(negedge clk);
    vectors++; if (err_at_b_q.size() != 2 || err_at_b_q[0] !== 1'b0 || err_at_b_q[1] !== 1'b1) begin miscompares++; $display("FAIL berr_sticky: n %0d at_b %b %b want 2/0/1", err_at_b_q.size(), err_at_b_q[0], err_at_b_q[1]); end
    vectors++; if (wr_error !== 1'b1 || nodes_written !== 32'd32) begin miscompares++; $display("FAIL berr_final: err %b count %0d want 1/32", wr_error, nodes_written); end
  endtask

  task automatic test_align_reset();
    int guard;
    apply_reset();
    w_delay = 3;
    do_start(32'h1000_0013);
    send_nodes(0, 16);
    guard = 0;
    while (axi.wvalid !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
    vectors++; if (axi.wvalid !== 1'b1 || aw_addr_q.size() != 1 || aw_addr_q[0] !== 32'h1000_0000) begin miscompares++; $display("FAIL align_addr: wvalid %b n %0d addr %h want 1/1/10000000", axi.wvalid, aw_addr_q.size(), aw_addr_q[0]); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if ({axi.awvalid, axi.wvalid, nif.node_ready, axi.wlast, axi.bready} !== 5'b00000) begin miscompares++; $display("FAIL async_rst_ctrl: got %b want 00000", {axi.awvalid, axi.wvalid, nif.node_ready, axi.wlast, axi.bready}); end
    vectors++; if (nodes_written !== 32'd0 || axi.wdata !== 64'd0 || axi.awaddr !== 32'd0) begin miscompares++; $display("FAIL async_rst_data: count %0d wdata %h awaddr %h want 0", nodes_written, axi.wdata, axi.awaddr); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; base_addr = '0;
    nif.node_valid = 1'b0; nif.node_in = '0;
    aw_delay = 0; w_delay = 0; b_delay = 0;
    for (int i = 0; i < 8; i++) bresp_plan[i] = 2'b00;
    test_reset();
    test_full_burst();
    test_partial_flush();
    test_flush_empty();
    test_stall();
    test_bresp_error();
    test_align_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/frontier_writer.md
Name: frontier_writer

Overview:
- Write-back stage directly downstream of the main execution engine.
- Accepts newly discovered node IDs on a valid/ready stream and packs two 32-bit IDs into each 64-bit beat.
- Writes the packed beats as AXI4 INCR bursts into the next-level frontier buffer at write_buffer_addr.
- Reports the written-node count that feeds nodes_written_count, and signals completion after a flush.

Parameters:
AXI_ADDR_WIDTH, 32, AXI address width
AXI_DATA_WIDTH, 64, AXI data width; fixed at 2*NODE_BITS
NODE_BITS, 32, node ID width
BURST_BEATS, 8, beats per full burst (power of two, 2..16)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; latches base_addr, clears count and error; ignored unless IDLE
base_addr  in  AXI_ADDR_WIDTH  frontier buffer base; low log2(BURST_BEATS*8) bits forced to 0
node_in  in  NODE_BITS  discovered node ID
node_valid  in  1  node_in valid
node_ready  out  1  stage can accept node_in
flush  in  1  pulse; drain any partial buffer, then finish
done  out  1  one-cycle pulse when flush has completed
nodes_written  out  32  nodes acknowledged by B channel since start
wr_error  out  1  sticky; set on any bresp != OKAY
m_axi_awaddr  out  AXI_ADDR_WIDTH  burst address
m_axi_awlen  out  8  beats-1
m_axi_awsize  out  3  constant 3'b011
m_axi_awburst  out  2  constant 2'b01 (INCR)
m_axi_awvalid  out  1  address valid
m_axi_awready  in  1  address accepted
m_axi_wdata  out  AXI_DATA_WIDTH  packed nodes, even index in [31:0]
m_axi_wstrb  out  8  byte strobes
m_axi_wlast  out  1  last beat of burst
m_axi_wvalid  out  1  data valid
m_axi_wready  in  1  data accepted
m_axi_bresp  in  2  write response
m_axi_bvalid  in  1  response valid
m_axi_bready  out  1  response accepted

Behaviour:
- Reset: state IDLE; node_ready=0, done=0, nodes_written=0, wr_error=0, awvalid=0, wvalid=0, wlast=0, bready=0; awaddr=0, wdata=0, wstrb=0.
- States: IDLE, FILL, AW, W, B, DONE.
- IDLE: on start, latch aligned base into wr_ptr, clear the node buffer (2*BURST_BEATS entries), fill count, nodes_written and wr_error, then go to FILL.
- FILL:
  - node_ready=1; each node_valid&node_ready writes buffer[fill] and increments fill.
  - When fill reaches 2*BURST_BEATS, go to AW the next cycle.
  - A flush seen in FILL is latched as flush_pend. A node accepted in the same cycle as flush is included.
  - flush_pend with fill>0: go to AW with a partial burst. flush_pend with fill==0: go to DONE.
- AW:
  - node_ready=0.
  - Drive awvalid=1 with awaddr=wr_ptr and awlen=ceil(fill/2)-1.
  - On awready, go to W. AW is held stable until accepted.
- W:
  - Beat k drives wdata={buffer[2k+1],buffer[2k]} and wstrb=8'hFF.
  - If the final beat has an odd node (fill odd), upper half = all ones and wstrb=8'h0F.
  - wlast=1 on beat ceil(fill/2)-1; advance k only on wvalid&wready.
  - After the last beat is accepted, go to B. W is issued only after AW is accepted.
- B:
  - bready=1. On bvalid, nodes_written += fill.
  - If bresp!=0, set wr_error (sticky); processing continues.
  - Then wr_ptr += ceil(fill/2)*8 (wraps modulo 2^AXI_ADDR_WIDTH) and fill=0.
  - Next state is DONE if flush_pend, else FILL.
- DONE: done=1 for exactly one cycle, clear flush_pend, then go to IDLE. nodes_written and wr_error hold until the next start.
- Latency: the first AW is asserted 1 cycle after the buffer fills or the flush is registered.
- Bursts are full-aligned, so they never cross a 4 KB boundary.
- Only one outstanding burst at a time.
- start outside IDLE is ignored. flush in IDLE produces no done.
- Asynchronous reset mid-burst aborts the transfer immediately; all outputs return to reset values.

Test Plan:
- start base=0x1000_0000, 16 nodes 0..15 back-to-back, zero-wait slave -> one AW addr 0x1000_0000 awlen=7; beat0 wdata=0x00000001_00000000; wlast on 8th beat; nodes_written=16.
- 35 nodes then flush -> bursts at 0x..00 and 0x..40 (awlen=7 each), then 0x..80 awlen=1; final beat wdata upper=0xFFFFFFFF, wstrb=0x0F; done pulse; nodes_written=35.
- flush immediately after start -> no AW issued, done pulses, nodes_written=0.
- Slave holds awready/wready low 5 cycles each, bvalid delayed 3 -> node_ready=0 throughout; AW/W signals stable; count updates only on the B handshake.
- bresp=2'b10 on the first burst, OKAY on the second -> wr_error=1 and stays 1; nodes_written still includes both bursts.
- base_addr=0x1000_0013 -> first awaddr=0x1000_0000. Assert rst_n low during W -> awvalid/wvalid/node_ready drop asynchronously to 0; nodes_written=0.
